// File: rtl/wb_arbiter.sv
// wb_arbiter: single register-file write port shared by the MEM/WB pipeline
// register and a 2-entry FIFO of long-latency results (divider, uncached load).
// The pipeline always wins; the FIFO drains in idle slots. A per-register busy
// scoreboard tracks long-latency destinations that are still in flight.
// Optional build macro WB_STARVE_LIMIT_EN adds pipe_stall_out, which forces a
// FIFO drain slot after STARVE_MAX consecutive full+pipeline cycles.
module wb_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int NREGS      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             pipe_we_in,
  input  logic [AW-1:0]    pipe_waddr_in,
  input  logic [DW-1:0]    pipe_wdata_in,
  input  logic             lu_valid_in,
  input  logic [AW-1:0]    lu_waddr_in,
  input  logic [DW-1:0]    lu_wdata_in,
  output logic             lu_ready_out,
  input  logic             issue_valid_in,
  input  logic [AW-1:0]    issue_waddr_in,
  output logic [NREGS-1:0] busy_out,
`ifdef WB_STARVE_LIMIT_EN
  output logic             pipe_stall_out,
`endif
  output logic             we_out,
  output logic [AW-1:0]    waddr_out,
  output logic [DW-1:0]    wdata_out,
  output logic [1:0]       pend_count_out
);

  logic [AW-1:0]    fifo_addr_q [2];
  logic [DW-1:0]    fifo_data_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [NREGS-1:0] busy_q, busy_d;

  logic             full, push, pop, sel_pipe;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;

  // Ready depends only on pre-pop occupancy, so pipe_we_in never reaches it.
  assign full         = (count_q == 2'd2);
  assign lu_ready_out = !full;
  assign push         = lu_valid_in && !full;
  assign head_addr    = fifo_addr_q[rd_ptr_q];
  assign head_data    = fifo_data_q[rd_ptr_q];

`ifdef WB_STARVE_LIMIT_EN
  localparam logic [2:0] STARVE_MAX_C = 3'(STARVE_MAX);

  logic       stall_q, stall_d;
  logic [2:0] starve_q, starve_d;

  // During the stall slot the FIFO head owns the port even if pipe_we_in is set.
  assign sel_pipe       = pipe_we_in && !stall_q;
  assign pipe_stall_out = stall_q;

  // Count consecutive full+pipeline cycles; fire a one-cycle stall at the limit.
  always_comb begin
    stall_d  = 1'b0;
    starve_d = 3'd0;
    if (!stall_q && full && pipe_we_in) begin
      if (3'(starve_q + 3'd1) == STARVE_MAX_C) begin
        stall_d = 1'b1;
      end else begin
        starve_d = 3'(starve_q + 3'd1);
      end
    end
  end

  // Starvation counter and stall flag.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      stall_q  <= 1'b0;
      starve_q <= 3'd0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end
`else
  assign sel_pipe = pipe_we_in;
`endif

  assign pop = !sel_pipe && (count_q != 2'd0);

  // Select the write source, advance FIFO pointers and update the scoreboard.
  always_comb begin
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    busy_d   = busy_q;
    count_d  = count_q + 2'(push) - 2'(pop);

    if (sel_pipe) begin
      we_d    = (pipe_waddr_in != '0);
      waddr_d = pipe_waddr_in;
      wdata_d = pipe_wdata_in;
    end else if (pop) begin
      we_d              = (head_addr != '0);
      waddr_d           = head_addr;
      wdata_d           = head_data;
      rd_ptr_d          = !rd_ptr_q;
      busy_d[head_addr] = 1'b0;
    end

    if (push) begin
      wr_ptr_d = !wr_ptr_q;
    end

    // A new issue to the same register overrides the completion clear.
    if (issue_valid_in && (issue_waddr_in != '0)) begin
      busy_d[issue_waddr_in] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  // FIFO storage; contents are only meaningful under count_q, so no reset.
  always_ff @(posedge clk_in) begin
    if (push && !reset_in) begin
      fifo_addr_q[wr_ptr_q] <= lu_waddr_in;
      fifo_data_q[wr_ptr_q] <= lu_wdata_in;
    end
  end

  assign we_out         = we_q;
  assign waddr_out      = waddr_q;
  assign wdata_out      = wdata_q;
  assign busy_out       = busy_q;
  assign pend_count_out = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the write-port rules.
module tb_wb_arbiter;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        pipe_we_in;
  logic [4:0]  pipe_waddr_in;
  logic [31:0] pipe_wdata_in;
  logic        lu_valid_in;
  logic [4:0]  lu_waddr_in;
  logic [31:0] lu_wdata_in;
  logic        lu_ready_out;
  logic        issue_valid_in;
  logic [4:0]  issue_waddr_in;
  logic [31:0] busy_out;
  logic        we_out;
  logic [4:0]  waddr_out;
  logic [31:0] wdata_out;
  logic [1:0]  pend_count_out;
`ifdef WB_STARVE_LIMIT_EN
  logic        pipe_stall_out;
`endif

  wb_arbiter dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .pipe_we_in     (pipe_we_in),
    .pipe_waddr_in  (pipe_waddr_in),
    .pipe_wdata_in  (pipe_wdata_in),
    .lu_valid_in    (lu_valid_in),
    .lu_waddr_in    (lu_waddr_in),
    .lu_wdata_in    (lu_wdata_in),
    .lu_ready_out   (lu_ready_out),
    .issue_valid_in (issue_valid_in),
    .issue_waddr_in (issue_waddr_in),
    .busy_out       (busy_out),
`ifdef WB_STARVE_LIMIT_EN
    .pipe_stall_out (pipe_stall_out),
`endif
    .we_out         (we_out),
    .waddr_out      (waddr_out),
    .wdata_out      (wdata_out),
    .pend_count_out (pend_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        fq[$];
  logic [31:0] busy_m;
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  bit          pre_ok;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check state-derived outputs, clock, check results.
  task automatic step(input logic rst, input logic pwe, input logic [4:0] pa,
                      input logic [31:0] pd, input logic lv, input logic [4:0] la,
                      input logic [31:0] ld, input logic iv, input logic [4:0] ia);
    bit   ready;
    ent_t h;
    ent_t n;
    reset_in       = rst;
    pipe_we_in     = pwe;
    pipe_waddr_in  = pa;
    pipe_wdata_in  = pd;
    lu_valid_in    = lv;
    lu_waddr_in    = la;
    lu_wdata_in    = ld;
    issue_valid_in = iv;
    issue_waddr_in = ia;
    if (pre_ok) begin
      chk("lu_ready", 64'(lu_ready_out), 64'(fq.size() < 2));
      chk("pend_count", 64'(pend_count_out), 64'(fq.size()));
      chk("busy", 64'(busy_out), 64'(busy_m));
    end
    ready = (fq.size() < 2);
    if (rst) begin
      fq.delete();
      busy_m    = '0;
      exp_we    = 1'b0;
      exp_waddr = '0;
      exp_wdata = '0;
    end else begin
      if (pwe) begin
        exp_we    = (pa != 0);
        exp_waddr = pa;
        exp_wdata = pd;
      end else if (fq.size() > 0) begin
        h = fq.pop_front();
        exp_we    = (h.a != 0);
        exp_waddr = h.a;
        exp_wdata = h.d;
        busy_m[h.a] = 1'b0;
      end else begin
        exp_we = 1'b0;
      end
      if (iv && ia != 0) busy_m[ia] = 1'b1;
      if (lv && ready) begin
        n.a = la;
        n.d = ld;
        fq.push_back(n);
      end
    end
    @(posedge clk_in);
    #1;
    chk("we", 64'(we_out), 64'(exp_we));
    chk("waddr", 64'(waddr_out), 64'(exp_waddr));
    chk("wdata", 64'(wdata_out), 64'(exp_wdata));
    pre_ok = 1'b1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic        lv, pw, iv, rst;
    logic [4:0]  la, pa, ia;
    logic [31:0] ld, pd;
    bit          accepted;
    total  = 0;
    bad    = 0;
    pre_ok = 1'b0;
    busy_m = '0;

    // Power-on reset.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_we", 64'(we_out), 64'd0);
    chk("rst_pend", 64'(pend_count_out), 64'd0);
    chk("rst_ready", 64'(lu_ready_out), 64'd1);

    // Pipeline-only write, visible for exactly one cycle.
    step(0, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("pipe_we", 64'(we_out), 64'd1);
    chk("pipe_waddr", 64'(waddr_out), 64'd3);
    chk("pipe_wdata", 64'(wdata_out), 64'hDEADBEEF);
    idle();
    chk("pipe_we_drop", 64'(we_out), 64'd0);

    // Long-latency path: issue, push, pop two edges after the push.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
    chk("busy7_set", 64'(busy_out[7]), 64'd1);
    step(0, 0, 0, 0, 1, 5'd7, 32'h1234, 0, 0);
    chk("ll_no_bypass", 64'(we_out), 64'd0);
    chk("ll_pend1", 64'(pend_count_out), 64'd1);
    idle();
    chk("ll_we", 64'(we_out), 64'd1);
    chk("ll_waddr", 64'(waddr_out), 64'd7);
    chk("ll_wdata", 64'(wdata_out), 64'h1234);
    chk("busy7_clr", 64'(busy_out[7]), 64'd0);

    // Fill FIFO under pipeline traffic, then starve it for three more cycles.
    step(0, 1, 5'd1, 32'hA1, 1, 5'd9, 32'h99, 1, 5'd9);
    step(0, 1, 5'd2, 32'hA2, 1, 5'd10, 32'h1010, 1, 5'd10);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 5'(11 + i), 32'hB0 + 32'(i), 1, 5'd20, 32'h2020, 0, 0);
      chk("bp_ready", 64'(lu_ready_out), 64'd0);
      chk("bp_waddr", 64'(waddr_out), 64'(11 + i));
    end
    idle();
    chk("drain_first", 64'(waddr_out), 64'd9);
    idle();
    chk("drain_second", 64'(waddr_out), 64'd10);
    chk("drain_busy", 64'(busy_out[10:9]), 64'd0);
    idle();

    // x0 head pops silently; set wins over clear on the same register.
    step(0, 0, 0, 0, 1, 5'd0, 32'h55, 0, 0);
    idle();
    chk("x0_we", 64'(we_out), 64'd0);
    chk("x0_pend", 64'(pend_count_out), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd4);
    step(0, 1, 5'd8, 32'h8, 1, 5'd4, 32'h44, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd4);
    chk("coll_we", 64'(we_out), 64'd1);
    chk("coll_waddr", 64'(waddr_out), 64'd4);
    chk("coll_busy4", 64'(busy_out[4]), 64'd1);

    // Reset in the middle of activity.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5);
    step(0, 1, 5'd6, 32'h6, 1, 5'd5, 32'h5, 0, 0);
    step(0, 1, 5'd6, 32'h7, 1, 5'd12, 32'h12, 0, 0);
    chk("mid_full", 64'(pend_count_out), 64'd2);
    step(1, 1, 5'd6, 32'h9, 1, 5'd13, 32'h13, 1, 5'd14);
    chk("mid_we", 64'(we_out), 64'd0);
    chk("mid_pend", 64'(pend_count_out), 64'd0);
    chk("mid_busy", 64'(busy_out), 64'd0);
    chk("mid_ready", 64'(lu_ready_out), 64'd1);

    // Random traffic; a refused long-latency result is held until accepted.
    lv = 0; la = 0; ld = 0;
    for (int i = 0; i < 600; i++) begin
      if (!lv) begin
        lv = ($urandom_range(0, 2) != 0);
        la = 5'($urandom_range(0, 31));
        ld = $urandom;
      end
      pw  = ($urandom_range(0, 2) == 0);
      pa  = 5'($urandom_range(0, 31));
      pd  = $urandom;
      iv  = ($urandom_range(0, 3) == 0);
      ia  = 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 79) == 0);
      accepted = lv && (fq.size() < 2);
      step(rst, pw, pa, pd, lv, la, ld, iv, ia);
      if (accepted || rst) lv = 0;
    end
    idle();
    idle();
    idle();
    chk("end_pend", 64'(pend_count_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
